// File: rtl/tcam_pkg.sv
// Shared types and constants for the ternary CAM lookup blocks.
package tcam_pkg;

  localparam int TCAM_WIDTH_DEF       = 32;
  localparam int TCAM_DEPTH_DEF       = 16;
  localparam int TCAM_INDEX_WIDTH_DEF = $clog2(TCAM_DEPTH_DEF);

  // A mask bit equal to this value removes that bit from the comparison.
  localparam logic TCAM_MASK_DONT_CARE = 1'b1;

  typedef struct packed {
    logic [TCAM_WIDTH_DEF-1:0] data;
    logic [TCAM_WIDTH_DEF-1:0] mask;
    logic                      valid;
  } tcam_entry_t;

  typedef struct packed {
    logic                            hit;
    logic                            multi;
    logic [TCAM_INDEX_WIDTH_DEF-1:0] idx;
    logic [TCAM_WIDTH_DEF-1:0]       data;
    logic [TCAM_INDEX_WIDTH_DEF:0]   cnt;
  } tcam_result_t;

endpackage

// File: rtl/tcam_prio_enc.sv
// Lowest-index priority encoder with any-hit and multi-hit flags; purely combinational.
module tcam_prio_enc #(
  parameter  int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // Scan downward so the lowest set bit is the last assignment to stick.
  always_comb begin
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_W'(i);
    end
  end

  assign any   = |match;
  assign multi = |(match & (match - DEPTH'(1)));

endmodule

// File: rtl/tcam_pipe.sv
// Two-stage pipelined ternary CAM with per-search key masking and valid/ready handshakes.
// Optional hit popcount on rslt_cnt is enabled by defining TCAM_HIT_CNT_EN.
module tcam_pipe
  import tcam_pkg::*;
#(
  parameter  int TCAM_WIDTH       = TCAM_WIDTH_DEF,
  parameter  int TCAM_DEPTH       = TCAM_DEPTH_DEF,
  localparam int TCAM_INDEX_WIDTH = $clog2(TCAM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [TCAM_INDEX_WIDTH-1:0] wr_idx,
  input  logic [TCAM_WIDTH-1:0]       wr_data,
  input  logic [TCAM_WIDTH-1:0]       wr_mask,
  input  logic                        wr_valid,
  input  logic                        flush,
  input  logic                        srch_valid,
  output logic                        srch_ready,
  input  logic [TCAM_WIDTH-1:0]       srch_key,
  input  logic [TCAM_WIDTH-1:0]       srch_key_mask,
  output logic                        rslt_valid,
  input  logic                        rslt_ready,
  output logic                        rslt_hit,
  output logic                        rslt_multi,
  output logic [TCAM_INDEX_WIDTH-1:0] rslt_idx,
  output logic [TCAM_WIDTH-1:0]       rslt_data,
  output logic [TCAM_INDEX_WIDTH:0]   rslt_cnt
);

  localparam logic [TCAM_WIDTH-1:0] DC_ALL = {TCAM_WIDTH{TCAM_MASK_DONT_CARE}};

  logic [TCAM_WIDTH-1:0]       data_q [TCAM_DEPTH];
  logic [TCAM_WIDTH-1:0]       mask_q [TCAM_DEPTH];
  logic [TCAM_DEPTH-1:0]       valid_q;
  logic [TCAM_DEPTH-1:0]       valid_nxt;
  logic                        stall;
  logic                        accept;
  logic [TCAM_DEPTH-1:0]       match_p0;
  logic [TCAM_DEPTH-1:0]       match_p1;
  logic                        vld_p1;
  logic [TCAM_INDEX_WIDTH-1:0] win_idx_p1;
  logic                        any_p1;
  logic                        multi_p1;
  logic [TCAM_INDEX_WIDTH:0]   cnt_p1;

  assign stall      = rslt_valid && !rslt_ready;
  assign srch_ready = !stall;
  assign accept     = srch_valid && srch_ready;

  // Flush clears everything, but a same-cycle write still lands its own valid bit.
  always_comb begin
    valid_nxt = flush ? '0 : valid_q;
    if (wr_en) valid_nxt[wr_idx] = wr_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < TCAM_DEPTH; i++) begin
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_nxt;
      if (wr_en) begin
        data_q[wr_idx] <= wr_data;
        mask_q[wr_idx] <= wr_mask;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < TCAM_DEPTH; i++) begin
      match_p0[i] = valid_q[i] &&
                    (((data_q[i] ^ srch_key) & (mask_q[i] ^ DC_ALL) & (srch_key_mask ^ DC_ALL)) == '0);
    end
  end

  // ---- stage 1: register match vector ----
  always_ff @(posedge clk) begin
    if (rst)         vld_p1 <= 1'b0;
    else if (!stall) vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (!stall) match_p1 <= match_p0;
  end

  tcam_prio_enc #(.DEPTH(TCAM_DEPTH)) u_prio_enc (
    .match (match_p1),
    .idx   (win_idx_p1),
    .any   (any_p1),
    .multi (multi_p1)
  );

`ifdef TCAM_HIT_CNT_EN
  function automatic logic [TCAM_INDEX_WIDTH:0] popcount(input logic [TCAM_DEPTH-1:0] v);
    logic [TCAM_INDEX_WIDTH:0] c;
    c = '0;
    for (int i = 0; i < TCAM_DEPTH; i++) c = c + {{TCAM_INDEX_WIDTH{1'b0}}, v[i]};
    return c;
  endfunction

  assign cnt_p1 = popcount(match_p1);
`else
  assign cnt_p1 = '0;
`endif

  // ---- stage 2: resolve winner, read its current data, register results ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rslt_valid <= 1'b0;
      rslt_hit   <= 1'b0;
      rslt_multi <= 1'b0;
      rslt_idx   <= '0;
      rslt_data  <= '0;
      rslt_cnt   <= '0;
    end else if (!stall) begin
      rslt_valid <= vld_p1;
      rslt_hit   <= any_p1;
      rslt_multi <= multi_p1;
      rslt_idx   <= any_p1 ? win_idx_p1 : '0;
      rslt_data  <= any_p1 ? data_q[win_idx_p1] : '0;
      rslt_cnt   <= cnt_p1;
    end
  end

endmodule

// File: tb/tb_tcam_pipe.sv
// Randomised and directed bench for tcam_pipe against a queue-based lookup model.
module tb_tcam_pipe;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int IW = 4;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  wr_mask;
  logic          wr_valid;
  logic          flush;
  logic          srch_valid;
  logic          srch_ready;
  logic [W-1:0]  srch_key;
  logic [W-1:0]  srch_key_mask;
  logic          rslt_valid;
  logic          rslt_ready;
  logic          rslt_hit;
  logic          rslt_multi;
  logic [IW-1:0] rslt_idx;
  logic [W-1:0]  rslt_data;
  logic [IW:0]   rslt_cnt;

  tcam_pipe #(.TCAM_WIDTH(W), .TCAM_DEPTH(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .wr_data       (wr_data),
    .wr_mask       (wr_mask),
    .wr_valid      (wr_valid),
    .flush         (flush),
    .srch_valid    (srch_valid),
    .srch_ready    (srch_ready),
    .srch_key      (srch_key),
    .srch_key_mask (srch_key_mask),
    .rslt_valid    (rslt_valid),
    .rslt_ready    (rslt_ready),
    .rslt_hit      (rslt_hit),
    .rslt_multi    (rslt_multi),
    .rslt_idx      (rslt_idx),
    .rslt_data     (rslt_data),
    .rslt_cnt      (rslt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit last_acc;

  // Reference table and outstanding-result queue.
  logic [W-1:0] m_data  [D];
  logic [W-1:0] m_mask  [D];
  bit           m_valid [D];

  typedef struct {
    bit           hit;
    bit           multi;
    int           idx;
    int           cnt;
    logic [W-1:0] data;
    bit           resolved;
    int           acc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      m_data[i]  = '0;
      m_mask[i]  = '0;
      m_valid[i] = 1'b0;
    end
    q.delete();
  endtask

  function automatic exp_t lookup(input logic [W-1:0] k, input logic [W-1:0] km);
    exp_t e;
    e.hit = 0; e.multi = 0; e.idx = 0; e.cnt = 0; e.data = '0; e.resolved = 0; e.acc = 0;
    for (int i = 0; i < D; i++) begin
      if (m_valid[i] && (((m_data[i] ^ k) & ~m_mask[i] & ~km) == '0)) begin
        if (!e.hit) e.idx = i;
        e.hit = 1;
        e.cnt++;
      end
    end
    e.multi = (e.cnt >= 2);
    return e;
  endfunction

  // One clock cycle: drive at negedge, check the settled outputs, advance the model.
  task automatic step(input bit i_rst, input bit i_wr_en, input int i_widx,
                      input logic [W-1:0] i_wdata, input logic [W-1:0] i_wmask,
                      input bit i_wvalid, input bit i_flush, input bit i_sv,
                      input logic [W-1:0] i_key, input logic [W-1:0] i_kmask, input bit i_rr);
    logic stall;
    exp_t e;
    int   exp_cnt;
    rst = i_rst; wr_en = i_wr_en; wr_idx = i_widx[IW-1:0]; wr_data = i_wdata;
    wr_mask = i_wmask; wr_valid = i_wvalid; flush = i_flush; srch_valid = i_sv;
    srch_key = i_key; srch_key_mask = i_kmask; rslt_ready = i_rr;
    #1;
    stall = rslt_valid && !rslt_ready;
    chk("srch_ready", {63'd0, srch_ready}, {63'd0, !stall});
    if (rslt_valid) begin
      if (q.size() == 0) begin
        chk("spurious_rslt_valid", {63'd0, rslt_valid}, 64'd0);
      end else begin
        e = q[0];
`ifdef TCAM_HIT_CNT_EN
        exp_cnt = e.cnt;
`else
        exp_cnt = 0;
`endif
        chk("rslt_hit",   {63'd0, rslt_hit},   {63'd0, e.hit});
        chk("rslt_multi", {63'd0, rslt_multi}, {63'd0, e.multi});
        chk("rslt_idx",   64'(rslt_idx),       64'(e.idx));
        chk("rslt_data",  64'(rslt_data),      64'(e.data));
        chk("rslt_cnt",   64'(rslt_cnt),       64'(exp_cnt));
        if (rslt_ready) void'(q.pop_front());
      end
    end
    // A search picks up its data in the first unstalled cycle after acceptance.
    if (!stall) begin
      for (int k = 0; k < q.size(); k++) begin
        if (!q[k].resolved && q[k].acc < cyc) begin
          e = q[k];
          e.data = e.hit ? m_data[e.idx] : '0;
          e.resolved = 1;
          q[k] = e;
        end
      end
    end
    last_acc = 0;
    if (i_rst) begin
      model_clear();
    end else begin
      if (i_sv && srch_ready) begin
        e = lookup(i_key, i_kmask);
        e.acc = cyc;
        q.push_back(e);
        last_acc = 1;
      end
      if (i_flush) for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
      if (i_wr_en) begin
        m_data[i_widx]  = i_wdata;
        m_mask[i_widx]  = i_wmask;
        m_valid[i_widx] = i_wvalid;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 1);
  endtask

  task automatic wr(input int idx, input logic [W-1:0] d, input logic [W-1:0] m, input bit v);
    step(0, 1, idx, d, m, v, 0, 0, '0, '0, 1);
  endtask

  task automatic srch(input logic [W-1:0] k, input logic [W-1:0] km);
    step(0, 0, 0, '0, '0, 0, 0, 1, k, km, 1);
  endtask

  task automatic chk_result(input string tag, input bit hit, input int idx,
                            input logic [W-1:0] data, input bit multi, input int cnt);
    int exp_cnt;
`ifdef TCAM_HIT_CNT_EN
    exp_cnt = cnt;
`else
    exp_cnt = 0;
`endif
    chk({tag, "_valid"}, {63'd0, rslt_valid}, 64'd1);
    chk({tag, "_hit"},   {63'd0, rslt_hit},   {63'd0, hit});
    chk({tag, "_idx"},   64'(rslt_idx),       64'(idx));
    chk({tag, "_data"},  64'(rslt_data),      64'(data));
    chk({tag, "_multi"}, {63'd0, rslt_multi}, {63'd0, multi});
    chk({tag, "_cnt"},   64'(rslt_cnt),       64'(exp_cnt));
  endtask

  logic [W-1:0] keys [4];
  int           kidx;

  initial begin
    rst = 1; wr_en = 0; wr_idx = '0; wr_data = '0; wr_mask = '0; wr_valid = 0; flush = 0;
    srch_valid = 0; srch_key = '0; srch_key_mask = '0; rslt_ready = 1;
    model_clear();
    @(negedge clk);
    step(1, 0, 0, '0, '0, 0, 0, 0, '0, '0, 1);
    step(1, 0, 0, '0, '0, 0, 0, 0, '0, '0, 1);
    chk("reset_rslt_valid", {63'd0, rslt_valid}, 64'd0);
    chk("reset_srch_ready", {63'd0, srch_ready}, 64'd1);
    chk("reset_hit",        {63'd0, rslt_hit},   64'd0);
    chk("reset_multi",      {63'd0, rslt_multi}, 64'd0);
    chk("reset_idx",        64'(rslt_idx),       64'd0);
    chk("reset_data",       64'(rslt_data),      64'd0);
    chk("reset_cnt",        64'(rslt_cnt),       64'd0);

    // Single exact entry, fixed two-cycle latency.
    wr(3, 32'hDEADBEEF, 32'h0, 1);
    srch(32'hDEADBEEF, 32'h0);
    chk("lat_early_valid", {63'd0, rslt_valid}, 64'd0);
    idle();
    chk_result("exact", 1, 3, 32'hDEADBEEF, 0, 1);
    idle();

    // Two overlapping entries: lowest index wins, multi-hit flagged.
    wr(2, 32'h12340000, 32'h0000FFFF, 1);
    wr(5, 32'h12345678, 32'h0, 1);
    srch(32'h12345678, 32'h0);
    idle();
    chk_result("multi", 1, 2, 32'h12340000, 1, 2);
    idle();

    // Per-search key mask, then the same key unmasked misses.
    wr(2, 32'h0, 32'h0, 0);
    srch(32'h12345679, 32'h0000000F);
    idle();
    chk_result("keymask", 1, 5, 32'h12345678, 0, 1);
    idle();
    srch(32'h12345679, 32'h0);
    idle();
    chk_result("miss", 0, 0, 32'h0, 0, 0);
    idle();

    // Back-pressure: stream four keys with the consumer stalled for four cycles.
    keys[0] = 32'hDEADBEEF; keys[1] = 32'h12345678; keys[2] = 32'h55555555; keys[3] = 32'h12345670;
    kidx = 0;
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 0, '0, '0, 0, 0, 1, keys[kidx], '0, 0);
      if (last_acc) kidx++;
    end
    chk("stall_srch_ready", {63'd0, srch_ready}, 64'd0);
    chk("stall_rslt_valid", {63'd0, rslt_valid}, 64'd1);
    for (int c = 0; c < 20 && kidx < 4; c++) begin
      step(0, 0, 0, '0, '0, 0, 0, 1, keys[kidx], '0, 1);
      if (last_acc) kidx++;
    end
    chk("stream_all_accepted", 64'(kidx), 64'd4);
    for (int c = 0; c < 4; c++) idle();
    chk("stream_drained", 64'(q.size()), 64'd0);

    // Flush with a simultaneous write.
    step(0, 1, 7, 32'hA5A5A5A5, 32'h0, 1, 1, 0, '0, '0, 1);
    srch(32'hA5A5A5A5, 32'h0);
    idle();
    chk_result("flush_wr", 1, 7, 32'hA5A5A5A5, 0, 1);
    idle();
    srch(32'h12345678, 32'h0);
    idle();
    chk_result("flush_old", 0, 0, 32'h0, 0, 0);
    idle();

    // Reset with searches in flight: nothing may emerge, table ends empty.
    srch(32'hA5A5A5A5, 32'h0);
    step(1, 0, 0, '0, '0, 0, 0, 1, 32'hA5A5A5A5, '0, 1);
    for (int c = 0; c < 3; c++) begin
      idle();
      chk("rst_inflight_valid", {63'd0, rslt_valid}, 64'd0);
    end
    chk("rst_srch_ready", {63'd0, srch_ready}, 64'd1);
    srch(32'h0, 32'hFFFFFFFF);
    idle();
    chk_result("rst_empty", 0, 0, 32'h0, 0, 0);
    idle();

    // Random traffic over a small key space so hits, multi-hits and stalls are common.
    for (int c = 0; c < 3000; c++) begin
      bit           r_rst, r_we, r_wv, r_fl, r_sv, r_rr;
      int           r_idx;
      logic [W-1:0] r_d, r_m, r_k, r_km;
      r_rst = ($urandom_range(0, 399) == 0);
      r_we  = ($urandom_range(0, 3) == 0);
      r_idx = $urandom_range(0, D - 1);
      r_d   = 32'hABCD0000 | ($urandom & 32'h0000000F);
      r_m   = ($urandom_range(0, 2) == 0) ? ($urandom & 32'h00000003) : 32'h0;
      if ($urandom_range(0, 15) == 0) r_m = r_m | 32'hFFFF0000;
      r_wv  = ($urandom_range(0, 7) != 0);
      r_fl  = ($urandom_range(0, 59) == 0);
      r_sv  = ($urandom_range(0, 3) != 0);
      r_k   = 32'hABCD0000 | ($urandom & 32'h0000000F);
      if ($urandom_range(0, 31) == 0) r_k = $urandom;
      r_km  = ($urandom_range(0, 4) == 0) ? ($urandom & 32'h0000000C) : 32'h0;
      r_rr  = ($urandom_range(0, 3) != 0);
      step(r_rst, r_we, r_idx, r_d, r_m, r_wv, r_fl, r_rst ? 1'b0 : r_sv, r_k, r_km, r_rr);
    end
    for (int c = 0; c < 5; c++) idle();
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
